// File: rtl/scan_display_7seg_if.sv
// Display bus: time/enable inputs toward the scanner, pins back out.
// master drives en/M0/M1/H0/H1/Dots; slave drives seg/dp/an/frame.
interface scan_display_7seg_if;
  logic       en;
  logic [3:0] M0;
  logic [3:0] M1;
  logic [3:0] H0;
  logic [1:0] H1;
  logic       Dots;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame;

  modport master (
    output en, M0, M1, H0, H1, Dots,
    input  seg, dp, an, frame
  );

  modport slave (
    input  en, M0, M1, H0, H1, Dots,
    output seg, dp, an, frame
  );
endinterface

// File: rtl/scan_display_7seg.sv
// 4-digit 7-seg scanner: per-frame time snapshot, blank gap per slot.
// Ports: clk, rst (async active-low), bus (slave: en,time in; seg/dp/an/frame out).
module scan_display_7seg #(
  parameter int DIV       = 2500,
  parameter int BLANK_CYC = 16,
  parameter bit SEG_AL    = 1'b1,
  parameter bit AN_AL     = 1'b1,
  parameter bit LZS       = 1'b1
) (
  input logic               clk,
  input logic               rst,
  scan_display_7seg_if.slave bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] BLK     = CW'(BLANK_CYC);

  typedef enum logic {
    S_BLANK,
    S_DRIVE
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;

  logic [1:0] h1_q, h1_d;
  logic [3:0] h0_q, h0_d;
  logic [3:0] m1_q, m1_d;
  logic [3:0] m0_q, m0_d;
  logic       dots_q, dots_d;

  logic       frame_q, frame_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [3:0] an_q, an_d;

  logic       wrap;
  logic       snap;
  logic [3:0] dig;
  logic       dig_blank;
  logic [6:0] seg_act;
  logic       dp_act;
  logic [3:0] an_act;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] p;
    p = 7'h00;
    unique case (d)
      4'd0: p = 7'h3F;
      4'd1: p = 7'h06;
      4'd2: p = 7'h5B;
      4'd3: p = 7'h4F;
      4'd4: p = 7'h66;
      4'd5: p = 7'h6D;
      4'd6: p = 7'h7D;
      4'd7: p = 7'h07;
      4'd8: p = 7'h7F;
      4'd9: p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  always_comb begin
    wrap  = (cnt_q == CNT_MAX);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? idx_q + 2'd1 : idx_q;
    snap  = wrap && (idx_q == 2'd3);
  end

  // Snapshot: hold the frame's time so no digit tears mid-frame.
  always_comb begin
    h1_d    = h1_q;
    h0_d    = h0_q;
    m1_d    = m1_q;
    m0_d    = m0_q;
    dots_d  = dots_q;
    frame_d = snap;
    if (snap) begin
      h1_d   = bus.H1;
      h0_d   = bus.H0;
      m1_d   = bus.M1;
      m0_d   = bus.M0;
      dots_d = bus.Dots;
    end
  end

  // Slot FSM tracks the phase of the current cnt value.
  always_comb begin
    state_d = (cnt_d < BLK) ? S_BLANK : S_DRIVE;
  end

  // H1=2'b11 would zero-extend to a valid 3, so it blanks explicitly.
  always_comb begin
    dig       = 4'hF;
    dig_blank = 1'b0;
    unique case (idx_q)
      2'd0: dig = m0_q;
      2'd1: dig = m1_q;
      2'd2: dig = h0_q;
      2'd3: begin
        dig       = {2'b00, h1_q};
        dig_blank = (h1_q == 2'b11) || (LZS && (h1_q == 2'b00));
      end
      default: dig = 4'hF;
    endcase
  end

  always_comb begin
    seg_act = 7'h00;
    dp_act  = 1'b0;
    an_act  = 4'h0;
    if (bus.en && (state_q == S_DRIVE)) begin
      an_act  = 4'b0001 << idx_q;
      seg_act = dig_blank ? 7'h00 : dec7(dig);
      dp_act  = (idx_q == 2'd2) && dots_q;
    end
    seg_d = seg_act ^ {7{SEG_AL}};
    dp_d  = dp_act ^ SEG_AL;
    an_d  = an_act ^ {4{AN_AL}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      state_q <= S_BLANK;
      h1_q    <= 2'b11;
      h0_q    <= 4'hF;
      m1_q    <= 4'hF;
      m0_q    <= 4'hF;
      dots_q  <= 1'b0;
      frame_q <= 1'b0;
      seg_q   <= {7{SEG_AL}};
      dp_q    <= SEG_AL;
      an_q    <= {4{AN_AL}};
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      h1_q    <= h1_d;
      h0_q    <= h0_d;
      m1_q    <= m1_d;
      m0_q    <= m0_d;
      dots_q  <= dots_d;
      frame_q <= frame_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.an    = an_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_scan_display_7seg.sv
// Directed bench for scan_display_7seg (DIV=8, BLANK_CYC=2).
// Cycle c counts posedges since reset release; sampled #1 after edge.
module tb_scan_display_7seg;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  scan_display_7seg_if bus ();

  scan_display_7seg #(
    .DIV      (8),
    .BLANK_CYC(2),
    .SEG_AL   (1'b1),
    .AN_AL    (1'b1),
    .LZS      (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (c=%0d)",
               tag, obs, exp, cyc);
    end
  endtask

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic pins(input string tag, input logic [3:0] an,
                      input logic [6:0] seg, input logic dp);
    chk({tag, ".an"}, 32'(bus.an), 32'(an));
    chk({tag, ".seg"}, 32'(bus.seg), 32'(seg));
    chk({tag, ".dp"}, 32'(bus.dp), 32'(dp));
  endtask

  task automatic set_t(input logic [1:0] h1, input logic [3:0] h0,
                       input logic [3:0] m1, input logic [3:0] m0,
                       input logic d);
    bus.H1   = h1;
    bus.H0   = h0;
    bus.M1   = m1;
    bus.M0   = m0;
    bus.Dots = d;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst   = 1'b0;
    bus.en = 1'b1;
    set_t(2'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    #12;
    pins("rst", 4'hF, 7'h7F, 1'b1);
    chk("rst.frame", 32'(bus.frame), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;

    // frame 0: snapshot still blank
    go(5);  pins("f0.d0", 4'hE, 7'h7F, 1'b1);
    go(13); pins("f0.d1", 4'hD, 7'h7F, 1'b1);
    go(31); chk("f0.frame", 32'(bus.frame), 32'd0);
    go(32); chk("f1.frame", 32'(bus.frame), 32'd1);
    go(33); chk("f1.frame_end", 32'(bus.frame), 32'd0);
            chk("gap1", 32'(bus.an), 32'hF);
    go(34); chk("gap2", 32'(bus.an), 32'hF);
    go(35); pins("f1.d0", 4'hE, 7'h19, 1'b1);
    go(40); chk("slot_end", 32'(bus.an), 32'hE);
    go(41); chk("gap_next", 32'(bus.an), 32'hF);
    go(43); pins("f1.d1", 4'hD, 7'h30, 1'b1);
    go(51); pins("f1.d2", 4'hB, 7'h24, 1'b1);
    go(59); pins("f1.d3", 4'h7, 7'h79, 1'b1);

    // minutes in blink code
    set_t(2'd1, 4'd2, 4'hF, 4'hF, 1'b0);
    go(67); pins("f2.d0", 4'hE, 7'h7F, 1'b1);
    go(75); pins("f2.d1", 4'hD, 7'h7F, 1'b1);
    go(83); pins("f2.d2", 4'hB, 7'h24, 1'b1);
    go(91); pins("f2.d3", 4'h7, 7'h79, 1'b1);

    // everything blank
    set_t(2'b11, 4'hF, 4'hF, 4'hF, 1'b0);
    go(99);  pins("f3.d0", 4'hE, 7'h7F, 1'b1);
    go(107); pins("f3.d1", 4'hD, 7'h7F, 1'b1);
    go(115); pins("f3.d2", 4'hB, 7'h7F, 1'b1);
    go(123); pins("f3.d3", 4'h7, 7'h7F, 1'b1);

    // 09:59 with dots, LZS on H1
    set_t(2'd0, 4'd9, 4'd5, 4'd9, 1'b1);
    go(131); pins("f4.d0", 4'hE, 7'h10, 1'b1);
    go(139); pins("f4.d1", 4'hD, 7'h12, 1'b1);
    go(146); pins("f4.gap", 4'hF, 7'h7F, 1'b1);
    go(147); pins("f4.d2", 4'hB, 7'h10, 1'b0);
    go(152); pins("f4.d2end", 4'hB, 7'h10, 1'b0);
    go(153); pins("f4.gap3", 4'hF, 7'h7F, 1'b1);
    go(155); pins("f4.lzs", 4'h7, 7'h7F, 1'b1);

    // dots off, M0 change mid-frame
    set_t(2'd0, 4'd9, 4'd5, 4'd7, 1'b0);
    go(163); pins("f5.d0", 4'hE, 7'h78, 1'b1);
    go(164); bus.M0 = 4'd8;
    go(166); pins("f5.hold", 4'hE, 7'h78, 1'b1);
    go(179); pins("f5.d2", 4'hB, 7'h10, 1'b1);
    go(195); pins("f6.d0", 4'hE, 7'h00, 1'b1);

    // enable off mid-DRIVE
    go(197); bus.en = 1'b0;
    go(198); pins("en0", 4'hF, 7'h7F, 1'b1);
    go(203); pins("en0.d1", 4'hF, 7'h7F, 1'b1);
    go(224); chk("en0.frame", 32'(bus.frame), 32'd1);
             chk("en0.an", 32'(bus.an), 32'hF);
    go(226); bus.en = 1'b1;
    go(227); pins("en1", 4'hE, 7'h00, 1'b1);

    // async reset mid-slot
    go(230);
    #2 rst = 1'b0;
    #1;
    pins("arst", 4'hF, 7'h7F, 1'b1);
    chk("arst.frame", 32'(bus.frame), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    go(5);  pins("r.f0", 4'hE, 7'h7F, 1'b1);
    go(32); chk("r.frame", 32'(bus.frame), 32'd1);
    go(35); pins("r.f1", 4'hE, 7'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
